audio_out_serializer: RTL and testbench
=======================================

AUDIO_OUT_SERIALIZER -- requirements
Module: audio_out_serializer

Interface
REQ-001 Parameter CLK_DIV, default 4, is the number of clk cycles per bclk half-period; legal range 2..255.
REQ-002 Parameter SAMPLE_W, default 16, is the sample width; only 16 is supported.
REQ-003 Port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port summed_output, input, 16 bits: mixed mono sample from the tone-summing stage, unsigned.
REQ-006 Port sample_valid, input, 1 bit: summed_output holds a new sample this cycle.
REQ-007 Port sample_ready, output, 1 bit: the holding buffer can accept a sample.
REQ-008 Port bclk, output, 1 bit: serial bit clock to the DAC.
REQ-009 Port lrclk, output, 1 bit: word select; 0 = left slot, 1 = right slot.
REQ-010 Port sdata, output, 1 bit: serial data, MSB first, I2S format.
REQ-011 Port underrun, output, 1 bit: one-clk pulse when a frame starts with the holding buffer empty.

Function
REQ-012 Divider counts 0..CLK_DIV-1; at terminal count it wraps to 0 and bclk toggles.
REQ-013 A bclk 1->0 toggle is a "shift edge"; the slot counter (5 bits, 0..31) increments by 1 mod 32 on each shift edge.
REQ-014 lrclk is registered and equals 1 when the slot counter is 16..31, else 0, updating on the shift edge.
REQ-015 A 1-entry holding buffer captures summed_output when sample_valid && sample_ready; sample_ready = buffer empty.
REQ-016 On the shift edge entering slot 1, the 32-bit frame register loads {buf, buf} (mono duplicated to L and R) and the buffer is marked empty.
REQ-017 If the buffer is empty at that edge, the frame register reloads the previous sample pair, and underrun pulses high for exactly that one clk.
REQ-018 On every other shift edge the frame register shifts left by 1, filling with 0; sdata = frame register bit 31.
REQ-019 Resulting I2S timing: left MSB in slot 1, left LSB in slot 16, right MSB in slot 17, right LSB in slot 0 of the next frame.
REQ-020 A handshake in the same clk as the slot-1 load is taken into the buffer after the load, so the buffer is full afterwards and no sample is lost.
REQ-021 sample_valid while sample_ready is 0 is ignored; the upstream stage holds the sample until ready.
REQ-022 Sample throughput is one per 64*CLK_DIV clk cycles.

Reset
REQ-023 While rst_n is 0: bclk=0, lrclk=0, sdata=0, underrun=0, sample_ready=1, divider=0, slot counter=0, frame register=0, previous sample=0, buffer empty.
REQ-024 Reset asserted mid-frame aborts the frame immediately; after release, the first shift edge occurs CLK_DIV*2 clk cycles later.

Configuration
REQ-025 Macro AUDIO_OUT_UNDERRUN_CNT_EN, when defined, adds output underrun_count, 16 bits, which increments on each underrun pulse, saturates at 16'hFFFF, and resets to 0.
REQ-026 Without AUDIO_OUT_UNDERRUN_CNT_EN, the port and counter are absent; all other behaviour is identical.

Structure
REQ-027 Package audio_pkg holds SAMPLE_W, FRAME_SLOTS=32, the slot-1 load index, and the sample typedef (16-bit).
REQ-028 Sub-module audio_clk_div generates the bclk level and the shift-edge strobe from CLK_DIV; the top holds the buffer, slot counter and frame register.

Verification
REQ-029 Reset check: rst_n=0 -> all outputs equal REQ-023 values; release -> first bclk rise after CLK_DIV clks, first shift edge after 2*CLK_DIV clks.
REQ-030 Single sample: with CLK_DIV=4, summed_output=16'hA5C3 handshaken before slot 1 -> sdata slots 1..16 = A5C3 MSB first, slots 17..0 = A5C3, and lrclk follows REQ-014.
REQ-031 Extremes: samples 16'h0000 then 16'hFFFF in consecutive frames -> sdata all-0 then all-1 (apart from the first slot 0), with no underrun.
REQ-032 Underrun: no sample is offered after 16'd10000 -> the next frame repeats 16'd10000, underrun pulses once, and underrun_count=1 when the macro is defined.
REQ-033 Backpressure: sample_valid held high with 16'd500 and the buffer full -> sample_ready=0, and exactly one capture occurs, on the clk after the slot-1 load.
REQ-034 Mid-frame reset: rst_n pulsed low at slot 9 -> outputs return to reset values immediately, and framing restarts cleanly from slot 0.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared constants and types for the I2S audio output path.
package audio_pkg;

    localparam int unsigned SAMPLE_W    = 16;
    localparam int unsigned FRAME_SLOTS = 32;
    localparam int unsigned FRAME_W     = 2 * SAMPLE_W;
    localparam int unsigned SLOT_W      = $clog2(FRAME_SLOTS);
    localparam int unsigned LOAD_SLOT   = 1;
    localparam int unsigned DIV_W       = 8;

    typedef logic [SAMPLE_W-1:0] sample_t;
    typedef logic [FRAME_W-1:0]  frame_t;

endpackage

// File: rtl/audio_clk_div.sv
// Bit-clock divider: bclk toggles every CLK_DIV clks; shift_edge flags the clk of each 1->0 toggle.
module audio_clk_div #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic bclk,
    output logic shift_edge
);
    import audio_pkg::*;

    localparam logic [DIV_W-1:0] TERM = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             bclk_q, bclk_d;
    logic             terminal;

    always_comb begin
        terminal = (cnt_q == TERM);
        cnt_d    = terminal ? '0 : cnt_q + 1'b1;
        bclk_d   = terminal ? ~bclk_q : bclk_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            bclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            bclk_q <= bclk_d;
        end
    end

    assign bclk       = bclk_q;
    assign shift_edge = terminal & bclk_q;

endmodule

// File: rtl/audio_out_serializer.sv
// Mono-to-I2S serializer with a 1-entry holding buffer and underrun repeat.
// Optional AUDIO_OUT_UNDERRUN_CNT_EN adds a saturating 16-bit underrun_count output.
module audio_out_serializer #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned SAMPLE_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SAMPLE_W-1:0] summed_output,
    input  logic                sample_valid,
    output logic                sample_ready,
    output logic                bclk,
    output logic                lrclk,
    output logic                sdata,
`ifdef AUDIO_OUT_UNDERRUN_CNT_EN
    output logic [15:0]         underrun_count,
`endif
    output logic                underrun
);
    import audio_pkg::*;

    localparam logic [SLOT_W-1:0] LOAD_IDX = SLOT_W'(LOAD_SLOT);

    logic              shift_edge;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic              lrclk_q, lrclk_d;
    frame_t            frame_q, frame_d;
    sample_t           buf_q, buf_d;
    sample_t           prev_q, prev_d;
    logic              full_q, full_d;
    logic              underrun_q, underrun_d;

    audio_clk_div #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .bclk      (bclk),
        .shift_edge(shift_edge)
    );

    always_comb begin
        slot_d     = slot_q;
        lrclk_d    = lrclk_q;
        frame_d    = frame_q;
        buf_d      = buf_q;
        prev_d     = prev_q;
        full_d     = full_q;
        underrun_d = 1'b0;

        if (shift_edge) begin
            slot_d  = slot_q + 1'b1;
            lrclk_d = slot_d[SLOT_W-1];
            if (slot_d == LOAD_IDX) begin
                if (full_q) begin
                    frame_d = {buf_q, buf_q};
                    prev_d  = buf_q;
                    full_d  = 1'b0;
                end else begin
                    frame_d    = {prev_q, prev_q};
                    underrun_d = 1'b1;
                end
            end else begin
                frame_d = {frame_q[FRAME_W-2:0], 1'b0};
            end
        end

        // Capture after the load so a same-clk handshake refills the buffer.
        if (sample_valid && !full_q) begin
            buf_d  = sample_t'(summed_output);
            full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q     <= '0;
            lrclk_q    <= 1'b0;
            frame_q    <= '0;
            buf_q      <= '0;
            prev_q     <= '0;
            full_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            slot_q     <= slot_d;
            lrclk_q    <= lrclk_d;
            frame_q    <= frame_d;
            buf_q      <= buf_d;
            prev_q     <= prev_d;
            full_q     <= full_d;
            underrun_q <= underrun_d;
        end
    end

`ifdef AUDIO_OUT_UNDERRUN_CNT_EN
    logic [15:0] ucnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ucnt_q <= '0;
        end else if (underrun_q && (ucnt_q != 16'hFFFF)) begin
            ucnt_q <= ucnt_q + 1'b1;
        end
    end

    assign underrun_count = ucnt_q;
`endif

    assign sample_ready = ~full_q;
    assign lrclk        = lrclk_q;
    assign sdata        = frame_q[FRAME_W-1];
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_audio_out_serializer.sv
// Directed self-checking bench for audio_out_serializer at CLK_DIV=4 (8 clks per bit, 256 per frame).
module tb_audio_out_serializer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] summed_output = '0;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic        bclk;
    logic        lrclk;
    logic        sdata;
    logic        underrun;
`ifdef AUDIO_OUT_UNDERRUN_CNT_EN
    logic [15:0] underrun_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int upulses  = 0;

    logic [31:0] word = '0;
    logic [31:0] lrw  = '0;
    logic [31:0] exp_word [1:7];
    logic [15:0] offer    [2:6];

    always #5 clk = ~clk;

    audio_out_serializer #(
        .CLK_DIV (4),
        .SAMPLE_W(16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .summed_output(summed_output),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .bclk         (bclk),
        .lrclk        (lrclk),
        .sdata        (sdata),
`ifdef AUDIO_OUT_UNDERRUN_CNT_EN
        .underrun_count(underrun_count),
`endif
        .underrun     (underrun)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Clk count (since reset release) of the shift edge that loads frame f.
    function automatic int lpos(input int f);
        return 8 + 256 * (f - 1);
    endfunction

    initial begin
        int f;
        int j;
        int rst_at;

        exp_word[1] = 32'hA5C3A5C3;
        exp_word[2] = 32'h00000000;
        exp_word[3] = 32'hFFFFFFFF;
        exp_word[4] = 32'h27102710;
        exp_word[5] = 32'h27102710;
        exp_word[6] = 32'h01900190;
        exp_word[7] = 32'h01F401F4;
        offer[2] = 16'h0000;
        offer[3] = 16'hFFFF;
        offer[4] = 16'd10000;
        offer[5] = 16'h0000;
        offer[6] = 16'd400;
        rst_at = lpos(8) + 68;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_bclk", {31'd0, bclk}, 32'd0);
        check_eq("rst_lrclk", {31'd0, lrclk}, 32'd0);
        check_eq("rst_sdata", {31'd0, sdata}, 32'd0);
        check_eq("rst_underrun", {31'd0, underrun}, 32'd0);
        check_eq("rst_ready", {31'd0, sample_ready}, 32'd1);

        @(negedge clk);
        rst_n = 1'b1;
        summed_output = 16'hA5C3;
        sample_valid  = 1'b1;

        for (int n = 1; n <= rst_at; n++) begin
            @(posedge clk);
            #1;
            if (underrun) upulses++;
            if (n == 1) check_eq("ready_after_capture", {31'd0, sample_ready}, 32'd0);
            if (n == 3) check_eq("bclk_before_rise", {31'd0, bclk}, 32'd0);
            if (n == 4) check_eq("bclk_first_rise", {31'd0, bclk}, 32'd1);
            if (n == 7) check_eq("sdata_before_shift", {31'd0, sdata}, 32'd0);
            if (n == 8) begin
                check_eq("bclk_first_fall", {31'd0, bclk}, 32'd0);
                check_eq("sdata_first_msb", {31'd0, sdata}, 32'd1);
                check_eq("ready_after_load", {31'd0, sample_ready}, 32'd1);
            end
            if (n == lpos(5)) check_eq("underrun_pulse_f5", {31'd0, underrun}, 32'd1);
            if (n == lpos(5) + 1) begin
                check_eq("underrun_one_clk", {31'd0, underrun}, 32'd0);
`ifdef AUDIO_OUT_UNDERRUN_CNT_EN
                check_eq("underrun_count_1", {16'd0, underrun_count}, 32'd1);
`endif
            end
            if (n == lpos(5) + 30) check_eq("bp_ready_low", {31'd0, sample_ready}, 32'd0);
            if (n == lpos(6)) check_eq("bp_ready_after_load", {31'd0, sample_ready}, 32'd1);
            if (n == lpos(6) + 1) check_eq("bp_single_capture", {31'd0, sample_ready}, 32'd0);

            if (n >= 8 && ((n - 8) % 8) == 4) begin
                f = (n - 8) / 256 + 1;
                j = ((n - 8) % 256) / 8;
                word = {word[30:0], sdata};
                lrw  = {lrw[30:0], lrclk};
                if (j == 31 && f <= 7) begin
                    check_eq($sformatf("frame%0d_sdata", f), word, exp_word[f]);
                    check_eq($sformatf("frame%0d_lrclk", f), lrw, 32'h0001FFFE);
                end
            end

            sample_valid = 1'b0;
            for (int k = 2; k <= 6; k++) begin
                if (k != 5 && n == lpos(k - 1) + 10) begin
                    sample_valid  = 1'b1;
                    summed_output = offer[k];
                end
            end
            if (n >= lpos(5) + 20 && n <= lpos(6)) begin
                sample_valid  = 1'b1;
                summed_output = 16'd500;
            end
            if (n == lpos(8) + 10) begin
                sample_valid  = 1'b1;
                summed_output = 16'h1234;
            end
        end

        check_eq("underrun_pulses", upulses, 32'd2);
`ifdef AUDIO_OUT_UNDERRUN_CNT_EN
        check_eq("underrun_count_2", {16'd0, underrun_count}, 32'd2);
`endif
        check_eq("pre_rst_sdata", {31'd0, sdata}, 32'd1);
        check_eq("pre_rst_bclk", {31'd0, bclk}, 32'd1);
        check_eq("pre_rst_ready", {31'd0, sample_ready}, 32'd0);

        // Asynchronous reset in slot 9, away from any clk edge.
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_bclk", {31'd0, bclk}, 32'd0);
        check_eq("mid_rst_lrclk", {31'd0, lrclk}, 32'd0);
        check_eq("mid_rst_sdata", {31'd0, sdata}, 32'd0);
        check_eq("mid_rst_underrun", {31'd0, underrun}, 32'd0);
        check_eq("mid_rst_ready", {31'd0, sample_ready}, 32'd1);
`ifdef AUDIO_OUT_UNDERRUN_CNT_EN
        check_eq("mid_rst_count", {16'd0, underrun_count}, 32'd0);
`endif
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_held_bclk", {31'd0, bclk}, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int m = 1; m <= 132; m++) begin
            @(posedge clk);
            #1;
            if (m == 3) check_eq("re_bclk_low", {31'd0, bclk}, 32'd0);
            if (m == 4) check_eq("re_bclk_rise", {31'd0, bclk}, 32'd1);
            if (m == 7) check_eq("re_no_underrun_early", {31'd0, underrun}, 32'd0);
            if (m == 8) begin
                check_eq("re_bclk_fall", {31'd0, bclk}, 32'd0);
                check_eq("re_underrun_slot1", {31'd0, underrun}, 32'd1);
                check_eq("re_sdata_zero", {31'd0, sdata}, 32'd0);
            end
            if (m == 9) begin
                check_eq("re_underrun_end", {31'd0, underrun}, 32'd0);
`ifdef AUDIO_OUT_UNDERRUN_CNT_EN
                check_eq("re_count_1", {16'd0, underrun_count}, 32'd1);
`endif
            end
            if (m == 124) check_eq("re_lrclk_slot15", {31'd0, lrclk}, 32'd0);
            if (m == 132) check_eq("re_lrclk_slot16", {31'd0, lrclk}, 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
